isa_imem_responder: RTL and testbench
=====================================

# isa_imem_responder

AHB3-Lite instruction-memory responder for the RV12 ISA checking environment. It sits on the core's instruction bus in place of a real memory and answers fetch transfers with words from a free `insn_i` input, or with NOPs on request. Each completed fetch is published on a registered log port, so the pipeline follower and ISA properties see the same instruction stream the core fetched. Bound next to the ISA property module under `riscv_top_ahb3lite`.

## Interface
- `BASE`, 32'h0000_0000, lowest valid fetch byte address.
- `SIZE`, 32'h0001_0000, size of the valid window in bytes; valid range is [BASE, BASE+SIZE).
- `WAIT_W`, 2, width of the wait-state request input.

Ports:
- `HCLK`  in  1  clock. All logic is on the rising edge.
- `HRESETn`  in  1  reset, asynchronous assert, active-low.
- `HSEL`  in  1  slave select.
- `HADDR`  in  32  transfer address.
- `HWRITE`  in  1  write transfer flag.
- `HSIZE`  in  3  transfer size.
- `HBURST`  in  3  burst type; ignored.
- `HPROT`  in  4  protection attributes; ignored.
- `HTRANS`  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HMASTLOCK`  in  1  locked transfer; ignored.
- `HREADY`  in  1  bus-wide ready; address phase is sampled only when this is high.
- `HWDATA`  in  32  write data; ignored.
- `HRDATA`  out  32  read data.
- `HREADYOUT`  out  1  slave ready.
- `HRESP`  out  1  0 = OKAY, 1 = ERROR.
- `insn_i`  in  32  instruction returned for the current fetch; sampled in the completing cycle.
- `nop_en_i`  in  1  when 1, return 32'h0000_0013 instead of `insn_i`.
- `wait_i`  in  WAIT_W  wait states for the transfer; sampled at address-phase accept.
- `fetch_valid_o`  out  1  one-cycle pulse: a fetch completed OKAY in the previous cycle.
- `fetch_addr_o`  out  32  address of the logged fetch.
- `fetch_insn_o`  out  32  data returned for the logged fetch.
- `fetch_cnt_o`  out  32  count of OKAY fetches; wraps modulo 2^32.

## Operation
- Accept condition: `HSEL & HREADY & HTRANS[1]`. IDLE and BUSY transfers get a zero-wait OKAY and are never logged.
- Error check at accept. The transfer is an error if any of the following holds:
  - `HWRITE`=1;
  - `HSIZE` != 3'b010;
  - `HADDR[1:0]` != 0;
  - `HADDR` < BASE;
  - `HADDR` - BASE >= SIZE, computed as a 32-bit unsigned comparison with no overflow (use a 33-bit difference).
- On accept, register the address and error flag, and load the wait counter from `wait_i`.
- States:
  - IDLE: `HREADYOUT`=1, `HRESP`=0.
  - WAIT: `HREADYOUT`=0, `HRESP`=0. The counter decrements each cycle. Go to DATA when the counter reaches 1 at the clock edge. An error transfer skips WAIT entirely.
  - DATA: `HREADYOUT`=1, `HRESP`=0. `HRDATA` = `nop_en_i` ? 32'h13 : `insn_i` (combinational from the inputs). The fetch completes in this cycle.
  - ERR1: `HREADYOUT`=0, `HRESP`=1.
  - ERR2: `HREADYOUT`=1, `HRESP`=1.
- Transitions on accept: an error goes to ERR1; `wait_i`=0 goes to DATA; otherwise go to WAIT.
- ERR1 always goes to ERR2.
- Pipelining: in DATA and ERR2, a simultaneous new accept is legal. Branch on the new transfer as from IDLE; with no new accept, return to IDLE.
- `HRDATA` = 0 in every cycle other than DATA.
- Log: in the cycle after DATA, `fetch_valid_o`=1 with the registered address and returned word, and `fetch_cnt_o` is incremented. `fetch_addr_o` and `fetch_insn_o` hold their values until the next log.
- A transfer accepted in ERR1 is a protocol violation and is not expected. The bench must not drive `HREADY` high while `HREADYOUT`=0.

## Timing
- Reset values: IDLE state, `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0, `fetch_valid_o`=0, `fetch_addr_o`=0, `fetch_insn_o`=0, `fetch_cnt_o`=0.
- Reset mid-transfer aborts the transfer immediately, with no log entry.
- Latency from accept to completing cycle is `1 + wait_i` cycles.
- An error response is always exactly 2 cycles.
- Log latency is 1 cycle after completion.
- Back-to-back zero-wait fetches sustain one fetch per cycle, with `fetch_valid_o` high continuously.

## Test plan
- Zero-wait fetch: reset, NONSEQ read at 32'h200, `wait_i`=0, `insn_i`=32'h00A0_0093. Required: `HREADYOUT`=1 and `HRDATA`=32'h00A0_0093 in the next cycle. One cycle later `fetch_valid_o`=1, `fetch_addr_o`=32'h200, `fetch_cnt_o`=1.
- Wait states: accept at 32'h204 with `wait_i`=3. Required: `HREADYOUT`=0 for 3 cycles, then 1 with data; exactly one log pulse.
- Error cases: `HADDR`=32'h202, then a write at 32'h208, then a read at BASE+SIZE. Each required to give `HREADYOUT` 0 then 1 with `HRESP`=1 on both cycles. `fetch_cnt_o` stays unchanged; no log pulse.
- NOP substitution and streaming: four back-to-back SEQ zero-wait fetches, with `nop_en_i`=1 on the second only. Required: `HRDATA` on the second is 32'h13. `fetch_valid_o` high for 4 consecutive cycles; addresses increment by 4.
- IDLE/BUSY and unselected: IDLE, BUSY, and NONSEQ with `HSEL`=0. Required: `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0, no log.
- Reset mid-WAIT: `wait_i`=3, assert `HRESETn`=0 in the 2nd wait cycle. Required: outputs go to reset values at once, and no `fetch_valid_o` pulse after release.

Source files
------------

// File: rtl/isa_imem_responder_if.sv
// AHB3-Lite slave-side bus bundle for the ISA instruction-memory responder.
// The master modport is the core/interconnect side; slave is the responder.
interface isa_imem_responder_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HMASTLOCK;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
             HREADY, HWDATA,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
             HREADY, HWDATA,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/isa_imem_responder.sv
// AHB3-Lite instruction-memory responder: answers word fetches from insn_i
// (or NOPs) with programmable wait states and logs every OKAY fetch.
module isa_imem_responder #(
   parameter logic [31:0] BASE   = 32'h0000_0000,
   parameter logic [31:0] SIZE   = 32'h0001_0000,
   parameter int          WAIT_W = 2
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   isa_imem_responder_if.slave bus,
   input  logic [31:0]       insn_i,
   input  logic              nop_en_i,
   input  logic [WAIT_W-1:0] wait_i,
   output logic              fetch_valid_o,
   output logic [31:0]       fetch_addr_o,
   output logic [31:0]       fetch_insn_o,
   output logic [31:0]       fetch_cnt_o
);

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t            state;
   logic [31:0]       addr_reg;
   logic [WAIT_W-1:0] wait_cnt;
   logic              hreadyout_reg;
   logic              hresp_reg;

   logic        accept;
   logic [32:0] offset;
   logic        range_err;
   logic        req_err;
   logic [31:0] rdata;
   logic        unused_inputs;

   assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

   // 33-bit offset: bit 32 flags an address below BASE without wrap-around.
   assign offset    = {1'b0, bus.HADDR} - {1'b0, BASE};
   assign range_err = offset[32] | (offset[31:0] >= SIZE);
   assign req_err   = bus.HWRITE | (bus.HSIZE != 3'b010) |
                      (bus.HADDR[1:0] != 2'b00) | range_err;

   assign rdata = nop_en_i ? NOP_INSN : insn_i;

   assign bus.HRDATA    = (state == S_DATA) ? rdata : 32'h0;
   assign bus.HREADYOUT = hreadyout_reg;
   assign bus.HRESP     = hresp_reg;

   assign unused_inputs = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HWDATA,
                            bus.HTRANS[0]};

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state         <= S_IDLE;
         addr_reg      <= 32'h0;
         wait_cnt      <= '0;
         hreadyout_reg <= 1'b1;
         hresp_reg     <= 1'b0;
         fetch_valid_o <= 1'b0;
         fetch_addr_o  <= 32'h0;
         fetch_insn_o  <= 32'h0;
         fetch_cnt_o   <= 32'h0;
      end else begin
         fetch_valid_o <= 1'b0;

         if (state == S_DATA) begin
            fetch_valid_o <= 1'b1;
            fetch_addr_o  <= addr_reg;
            fetch_insn_o  <= rdata;
            fetch_cnt_o   <= fetch_cnt_o + 32'd1;
         end

         case (state)
            S_WAIT: begin
               if (wait_cnt == WAIT_W'(1)) begin
                  state         <= S_DATA;
                  hreadyout_reg <= 1'b1;
                  hresp_reg     <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end
            end

            S_ERR1: begin
               state         <= S_ERR2;
               hreadyout_reg <= 1'b1;
               hresp_reg     <= 1'b1;
            end

            // IDLE, DATA and ERR2 all accept a new address phase.
            default: begin
               if (accept) begin
                  addr_reg <= bus.HADDR;
                  wait_cnt <= wait_i;
                  if (req_err) begin
                     state         <= S_ERR1;
                     hreadyout_reg <= 1'b0;
                     hresp_reg     <= 1'b1;
                  end else if (wait_i == '0) begin
                     state         <= S_DATA;
                     hreadyout_reg <= 1'b1;
                     hresp_reg     <= 1'b0;
                  end else begin
                     state         <= S_WAIT;
                     hreadyout_reg <= 1'b0;
                     hresp_reg     <= 1'b0;
                  end
               end else begin
                  state         <= S_IDLE;
                  hreadyout_reg <= 1'b1;
                  hresp_reg     <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_isa_imem_responder.sv
// Directed plus randomized checks of isa_imem_responder against a
// transaction-level expectation of response, data and fetch log.
module tb_isa_imem_responder;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam logic [31:0] SIZE = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] insn;
   logic        nop_en;
   logic [1:0]  wait_v;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic [31:0] fetch_insn;
   logic [31:0] fetch_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_cnt   = 32'h0;
   logic [31:0] exp_laddr = 32'h0;
   logic [31:0] exp_linsn = 32'h0;

   always #5 clk = ~clk;

   isa_imem_responder_if bus ();
   // Single-slave bus: the global ready is simply this slave's ready.
   assign bus.HREADY = bus.HREADYOUT;

   isa_imem_responder #(.BASE(BASE), .SIZE(SIZE), .WAIT_W(2)) dut (
      .HCLK          (clk),
      .HRESETn       (rst_n),
      .bus           (bus),
      .insn_i        (insn),
      .nop_en_i      (nop_en),
      .wait_i        (wait_v),
      .fetch_valid_o (fetch_valid),
      .fetch_addr_o  (fetch_addr),
      .fetch_insn_o  (fetch_insn),
      .fetch_cnt_o   (fetch_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.HSEL      = 1'b0;
      bus.HADDR     = 32'h0;
      bus.HWRITE    = 1'b0;
      bus.HSIZE     = 3'b010;
      bus.HBURST    = 3'b000;
      bus.HPROT     = 4'b0011;
      bus.HTRANS    = 2'b00;
      bus.HMASTLOCK = 1'b0;
      bus.HWDATA    = 32'h0;
      wait_v        = 2'd0;
   endtask

   task automatic chk_resp(input string tag, input logic rdy, input logic resp,
                           input logic [31:0] data);
      chk({tag, "_rdy"}, 32'(bus.HREADYOUT), 32'(rdy));
      chk({tag, "_resp"}, 32'(bus.HRESP), 32'(resp));
      chk({tag, "_rdata"}, bus.HRDATA, data);
   endtask

   task automatic chk_log(input string tag, input logic valid);
      chk({tag, "_lvalid"}, 32'(fetch_valid), 32'(valid));
      chk({tag, "_laddr"}, fetch_addr, exp_laddr);
      chk({tag, "_linsn"}, fetch_insn, exp_linsn);
      chk({tag, "_lcnt"}, fetch_cnt, exp_cnt);
   endtask

   // Error rule stated on whole numbers: outside [BASE, BASE+SIZE) or malformed.
   function automatic bit model_err(input logic [31:0] addr, input bit wr,
                                    input logic [2:0] size);
      logic [63:0] a64;
      logic [63:0] lo;
      logic [63:0] hi;
      a64 = {32'h0, addr};
      lo  = {32'h0, BASE};
      hi  = {32'h0, BASE} + {32'h0, SIZE};
      return wr || (size != 3'd2) || (addr % 4 != 0) || (a64 < lo) || (a64 >= hi);
   endfunction

   // One complete, non-pipelined transfer with all data-phase and log checks.
   task automatic xfer(input string tag, input logic [31:0] addr, input bit wr,
                       input logic [2:0] size, input logic [1:0] trans,
                       input bit sel, input int w, input logic [31:0] word,
                       input bit nop);
      bit          acc;
      bit          err;
      logic [31:0] exp_data;
      acc = sel && (trans == 2'd2 || trans == 2'd3);
      err = acc && model_err(addr, wr, size);
      exp_data = nop ? 32'h13 : word;

      bus.HSEL   = sel;
      bus.HADDR  = addr;
      bus.HWRITE = wr;
      bus.HSIZE  = size;
      bus.HTRANS = trans;
      wait_v     = w[1:0];
      insn       = ~word;
      nop_en     = 1'b0;
      #1;
      chk_resp({tag, "_addr"}, 1'b1, 1'b0, 32'h0);
      tick();
      idle_bus();

      if (!acc) begin
         chk_resp({tag, "_noacc"}, 1'b1, 1'b0, 32'h0);
         chk_log({tag, "_noacc"}, 1'b0);
      end else if (err) begin
         chk_resp({tag, "_err1"}, 1'b0, 1'b1, 32'h0);
         tick();
         chk_resp({tag, "_err2"}, 1'b1, 1'b1, 32'h0);
         tick();
         chk_log({tag, "_errlog"}, 1'b0);
      end else begin
         for (int i = 0; i < w; i++) begin
            chk_resp({tag, "_wait"}, 1'b0, 1'b0, 32'h0);
            chk({tag, "_wait_lvalid"}, 32'(fetch_valid), 32'h0);
            tick();
         end
         insn   = word;
         nop_en = nop;
         #1;
         chk_resp({tag, "_data"}, 1'b1, 1'b0, exp_data);
         chk({tag, "_data_lvalid"}, 32'(fetch_valid), 32'h0);
         tick();
         insn   = ~word;
         nop_en = 1'b0;
         exp_cnt   = exp_cnt + 32'd1;
         exp_laddr = addr;
         exp_linsn = exp_data;
         chk_log({tag, "_log"}, 1'b1);
      end
   endtask

   initial begin
      logic [31:0] words [4];
      logic [31:0] sdata [4];
      logic [31:0] raddr;
      logic [2:0]  rsize;
      logic [1:0]  rtrans;
      int          pick;

      idle_bus();
      insn   = 32'h0;
      nop_en = 1'b0;

      // Reset state
      tick();
      tick();
      chk_resp("reset", 1'b1, 1'b0, 32'h0);
      chk_log("reset", 1'b0);
      rst_n = 1'b1;
      tick();

      // Zero-wait and wait-state fetches
      xfer("zw", 32'h200, 1'b0, 3'd2, 2'd2, 1'b1, 0, 32'h00A0_0093, 1'b0);
      xfer("w3", 32'h204, 1'b0, 3'd2, 2'd2, 1'b1, 3, 32'h0010_0113, 1'b0);

      // Error responses
      xfer("unal", 32'h202, 1'b0, 3'd2, 2'd2, 1'b1, 0, 32'h1111_1111, 1'b0);
      xfer("wr",   32'h208, 1'b1, 3'd2, 2'd2, 1'b1, 2, 32'h2222_2222, 1'b0);
      xfer("top",  BASE + SIZE, 1'b0, 3'd2, 2'd2, 1'b1, 1, 32'h3333_3333, 1'b0);
      xfer("last", BASE + SIZE - 32'd4, 1'b0, 3'd2, 2'd2, 1'b1, 1, 32'h4444_4444, 1'b0);
      xfer("wrap", 32'hFFFF_FFFC, 1'b0, 3'd2, 2'd2, 1'b1, 0, 32'h5555_5555, 1'b0);
      xfer("byte", 32'h20C, 1'b0, 3'd0, 2'd2, 1'b1, 0, 32'h6666_6666, 1'b0);

      // IDLE, BUSY and unselected
      xfer("idle",  32'h210, 1'b0, 3'd2, 2'd0, 1'b1, 0, 32'h7777_7777, 1'b0);
      xfer("busy",  32'h214, 1'b0, 3'd2, 2'd1, 1'b1, 0, 32'h8888_8888, 1'b0);
      xfer("nosel", 32'h218, 1'b0, 3'd2, 2'd2, 1'b0, 0, 32'h9999_9999, 1'b0);

      // Four back-to-back zero-wait fetches, NOP substituted on the second
      for (int k = 0; k < 4; k++) begin
         words[k] = $urandom;
         sdata[k] = (k == 1) ? 32'h13 : words[k];
      end
      for (int c = 0; c < 6; c++) begin
         if (c < 4) begin
            bus.HSEL   = 1'b1;
            bus.HADDR  = 32'h300 + 32'(4 * c);
            bus.HWRITE = 1'b0;
            bus.HSIZE  = 3'b010;
            bus.HTRANS = (c == 0) ? 2'd2 : 2'd3;
            wait_v     = 2'd0;
         end else begin
            idle_bus();
         end
         if (c >= 1 && c <= 4) begin
            insn   = words[c-1];
            nop_en = (c == 2);
         end else begin
            insn   = $urandom;
            nop_en = 1'b0;
         end
         #1;
         chk_resp("stream", 1'b1, 1'b0, (c >= 1 && c <= 4) ? sdata[c-1] : 32'h0);
         if (c >= 2) begin
            exp_cnt   = exp_cnt + 32'd1;
            exp_laddr = 32'h300 + 32'(4 * (c - 2));
            exp_linsn = sdata[c-2];
            chk_log("stream", 1'b1);
         end else if (c == 1) begin
            chk("stream_lvalid0", 32'(fetch_valid), 32'h0);
         end
         tick();
      end
      chk("stream_end_lvalid", 32'(fetch_valid), 32'h0);

      // Randomized transfers against the transaction model
      for (int n = 0; n < 60; n++) begin
         pick = $urandom_range(0, 9);
         case (pick)
            0: raddr = BASE + SIZE - 32'd4 + 32'(4 * $urandom_range(0, 2));
            1: raddr = $urandom;
            2: raddr = BASE + 32'($urandom_range(0, 32'h3FFF) * 4 + $urandom_range(1, 3));
            default: raddr = BASE + 32'($urandom_range(0, 32'h3FFF) * 4);
         endcase
         rsize  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         rtrans = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
         xfer("rnd", raddr, ($urandom_range(0, 9) == 0), rsize, rtrans,
              ($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom,
              ($urandom_range(0, 3) == 0));
      end

      // Reset in the second wait cycle
      bus.HSEL   = 1'b1;
      bus.HADDR  = 32'h220;
      bus.HTRANS = 2'd2;
      wait_v     = 2'd3;
      insn       = 32'hDEAD_BEEF;
      tick();
      idle_bus();
      chk_resp("rstw1", 1'b0, 1'b0, 32'h0);
      tick();
      chk_resp("rstw2", 1'b0, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      exp_cnt   = 32'h0;
      exp_laddr = 32'h0;
      exp_linsn = 32'h0;
      chk_resp("rst_now", 1'b1, 1'b0, 32'h0);
      chk_log("rst_now", 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_resp("post_rst", 1'b1, 1'b0, 32'h0);
         chk_log("post_rst", 1'b0);
      end

      // Fetching works again after the abort
      xfer("after", 32'h224, 1'b0, 3'd2, 2'd3, 1'b1, 1, 32'h0000_0073, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
